// File: rtl/grf_wb_arbiter.sv
// Shares the single GRF write port between the W-stage pipeline and a queued late-return source.
// Optional WB_TRACE_EN prints each committed register write (simulation only).
module grf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_we,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_addr,
    input  logic [31:0] s_wd,
    input  logic [31:0] s_pc,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic        stall_req,
    output logic        grf_we,
    output logic [4:0]  grf_addr,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    localparam logic [1:0] LAST_PTR   = 2'(DEPTH - 1);
    localparam logic [2:0] FULL_CNT   = 3'(DEPTH);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    // Storage is sized for the largest legal DEPTH; slots at or above DEPTH are never addressed.
    logic [4:0]  e_addr [4];
    logic [31:0] e_wd   [4];
    logic [31:0] e_pc   [4];
    logic [3:0]  e_vld;
    logic [3:0]  e_vld_nxt;
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;
    logic [7:0]  starve_cnt;

    logic empty;
    logic head_vld;
    logic p_req;
    logic grant_pipe;
    logic grant_head;
    logic write_head;
    logic pop;
    logic push;
    logic push_killed;

    function automatic logic [1:0] inc_ptr(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    // Secondary handshake: a transfer happens on a rising edge where s_valid && s_ready.
    // s_ready depends only on the registered occupancy, never on a same-cycle pop, and is
    // low while reset is asserted. Transfers to $0 complete but are dropped.
    always_comb begin
        empty       = (count == 3'd0);
        head_vld    = !empty && e_vld[rd_ptr];
        p_req       = p_we && (p_addr != 5'd0);
        stall_req   = (starve_cnt == STARVE_LIM);
        grant_pipe  = p_req && !stall_req;
        grant_head  = !empty && !grant_pipe;
        write_head  = grant_head && head_vld;
        // A killed head is drained even while the pipeline owns the port.
        pop         = !empty && (grant_head || !e_vld[rd_ptr]);
        s_ready     = reset && (count < FULL_CNT);
        push        = s_valid && s_ready && (s_addr != 5'd0);
        push_killed = grant_pipe && (s_addr == p_addr);
    end

    always_comb begin
        e_vld_nxt = e_vld;
        for (int i = 0; i < 4; i++) begin
            if (grant_pipe && (e_addr[i] == p_addr)) e_vld_nxt[i] = 1'b0;
        end
        if (pop) e_vld_nxt[rd_ptr] = 1'b0;
        if (push) e_vld_nxt[wr_ptr] = !push_killed;
    end

    always_comb begin
        q_busy1 = 1'b0;
        q_busy2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (e_vld[i] && (e_addr[i] == q_addr1) && (q_addr1 != 5'd0)) q_busy1 = 1'b1;
            if (e_vld[i] && (e_addr[i] == q_addr2) && (q_addr2 != 5'd0)) q_busy2 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_vld      <= 4'd0;
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            count      <= 3'd0;
            starve_cnt <= 8'd0;
        end else begin
            e_vld <= e_vld_nxt;
            if (pop) rd_ptr <= inc_ptr(rd_ptr);
            if (push) wr_ptr <= inc_ptr(wr_ptr);
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (grant_head || empty) starve_cnt <= 8'd0;
            else if (head_vld && (starve_cnt != STARVE_LIM)) starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Payload needs no reset: validity alone decides whether a slot means anything.
    always_ff @(posedge clk) begin
        if (push) begin
            e_addr[wr_ptr] <= s_addr;
            e_wd[wr_ptr]   <= s_wd;
            e_pc[wr_ptr]   <= s_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grf_we   <= 1'b0;
            grf_addr <= 5'd0;
            grf_wd   <= 32'd0;
            grf_pc   <= 32'd0;
        end else begin
            grf_we <= grant_pipe || write_head;
            if (grant_pipe) begin
                grf_addr <= p_addr;
                grf_wd   <= p_wd;
                grf_pc   <= p_pc;
            end else if (write_head) begin
                grf_addr <= e_addr[rd_ptr];
                grf_wd   <= e_wd[rd_ptr];
                grf_pc   <= e_pc[rd_ptr];
            end
        end
    end

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (reset && grf_we && (grf_addr != 5'd0)) $display("@%h: $%d <= %h", grf_pc, grf_addr, grf_wd);
    end
`else
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter (DEPTH=2, STARVE_MAX=4): hand-computed expectations per step.
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p_we = 1'b0;
    logic [4:0]  p_addr = '0;
    logic [31:0] p_wd = '0;
    logic [31:0] p_pc = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [4:0]  s_addr = '0;
    logic [31:0] s_wd = '0;
    logic [31:0] s_pc = '0;
    logic [4:0]  q_addr1 = '0;
    logic [4:0]  q_addr2 = '0;
    logic        q_busy1;
    logic        q_busy2;
    logic        stall_req;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    int n_checks = 0;
    int n_errors = 0;

    grf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .p_we(p_we), .p_addr(p_addr), .p_wd(p_wd), .p_pc(p_pc),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wd(s_wd), .s_pc(s_pc),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .stall_req(stall_req),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_wd(grf_wd), .grf_pc(grf_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_grf(input string tag, input logic we, input logic [4:0] a,
                           input logic [31:0] wd, input logic [31:0] pc);
        chk({tag, "_we"}, 32'(grf_we), 32'(we));
        chk({tag, "_addr"}, 32'(grf_addr), 32'(a));
        chk({tag, "_wd"}, grf_wd, wd);
        chk({tag, "_pc"}, grf_pc, pc);
    endtask

    task automatic drive_p(input logic we, input logic [4:0] a, input logic [31:0] wd, input logic [31:0] pc);
        p_we = we; p_addr = a; p_wd = wd; p_pc = pc;
    endtask

    task automatic drive_s(input logic v, input logic [4:0] a, input logic [31:0] wd, input logic [31:0] pc);
        s_valid = v; s_addr = a; s_wd = wd; s_pc = pc;
    endtask

    initial begin
        // Reset state
        #2;
        q_addr1 = 5'd5;
        chk("rst_grf_we", 32'(grf_we), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_busy1", 32'(q_busy1), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("rel_s_ready", 32'(s_ready), 32'd1);
        tick();

        // Pipeline write alone, then a $0 write that must not reach the GRF
        drive_p(1'b1, 5'd5, 32'h11, 32'h100);
        tick();
        chk_grf("p5", 1'b1, 5'd5, 32'h11, 32'h100);
        drive_p(1'b1, 5'd0, 32'h22, 32'h104);
        tick();
        chk_grf("p0", 1'b0, 5'd5, 32'h11, 32'h100);

        // Secondary $8 waits while the pipeline is busy for three cycles
        q_addr1 = 5'd8;
        drive_p(1'b1, 5'd3, 32'h33, 32'h108);
        drive_s(1'b1, 5'd8, 32'hAA, 32'h200);
        #1;
        chk("s8_ready", 32'(s_ready), 32'd1);
        chk("s8_busy_same_cycle", 32'(q_busy1), 32'd0);
        tick();
        drive_s(1'b0, 5'd0, 32'h0, 32'h0);
        chk_grf("p3_a", 1'b1, 5'd3, 32'h33, 32'h108);
        chk("s8_busy_queued", 32'(q_busy1), 32'd1);
        tick();
        tick();
        chk("s8_no_stall", 32'(stall_req), 32'd0);
        drive_p(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        chk("s8_busy_before_grant", 32'(q_busy1), 32'd1);
        tick();
        chk_grf("s8_write", 1'b1, 5'd8, 32'hAA, 32'h200);
        chk("s8_busy_after", 32'(q_busy1), 32'd0);

        // WAW kill of a queued entry
        q_addr1 = 5'd9;
        drive_s(1'b1, 5'd9, 32'h1, 32'h210);
        tick();
        drive_s(1'b0, 5'd0, 32'h0, 32'h0);
        chk("s9_queued_grf_we", 32'(grf_we), 32'd0);
        chk("s9_busy", 32'(q_busy1), 32'd1);
        drive_p(1'b1, 5'd9, 32'h2, 32'h300);
        tick();
        drive_p(1'b0, 5'd0, 32'h0, 32'h0);
        chk_grf("p9_write", 1'b1, 5'd9, 32'h2, 32'h300);
        chk("s9_killed_busy", 32'(q_busy1), 32'd0);
        tick();
        chk_grf("s9_killed_drain", 1'b0, 5'd9, 32'h2, 32'h300);

        // WAW kill of an entry pushed in the same cycle
        q_addr1 = 5'd12;
        drive_s(1'b1, 5'd12, 32'hEE, 32'h220);
        drive_p(1'b1, 5'd12, 32'hC0, 32'h304);
        tick();
        drive_s(1'b0, 5'd0, 32'h0, 32'h0);
        drive_p(1'b0, 5'd0, 32'h0, 32'h0);
        chk_grf("p12_write", 1'b1, 5'd12, 32'hC0, 32'h304);
        chk("s12_push_killed_busy", 32'(q_busy1), 32'd0);
        tick();
        chk_grf("s12_killed_drain", 1'b0, 5'd12, 32'hC0, 32'h304);

        // Fill the two-entry queue; a third request is held, then writes leave in order
        q_addr1 = 5'd10;
        q_addr2 = 5'd11;
        drive_p(1'b1, 5'd4, 32'h44, 32'h308);
        drive_s(1'b1, 5'd10, 32'hA1, 32'h400);
        tick();
        drive_s(1'b1, 5'd11, 32'hA2, 32'h404);
        #1;
        chk("fill_ready2", 32'(s_ready), 32'd1);
        tick();
        chk("fill_busy1", 32'(q_busy1), 32'd1);
        chk("fill_busy2", 32'(q_busy2), 32'd1);
        drive_p(1'b0, 5'd0, 32'h0, 32'h0);
        drive_s(1'b1, 5'd12, 32'hA3, 32'h408);
        #1;
        chk("full_pop_not_ready", 32'(s_ready), 32'd0);
        tick();
        chk_grf("fifo_w10", 1'b1, 5'd10, 32'hA1, 32'h400);
        chk("third_ready", 32'(s_ready), 32'd1);
        tick();
        drive_s(1'b0, 5'd0, 32'h0, 32'h0);
        chk_grf("fifo_w11", 1'b1, 5'd11, 32'hA2, 32'h404);
        tick();
        chk_grf("fifo_w12", 1'b1, 5'd12, 32'hA3, 32'h408);
        tick();
        chk("fifo_idle", 32'(grf_we), 32'd0);

        // Starvation: pipeline writes every cycle, stall_req rises on the 5th denied cycle
        drive_p(1'b1, 5'd6, 32'h60, 32'h500);
        drive_s(1'b1, 5'd13, 32'hD0, 32'h600);
        tick();
        drive_s(1'b0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("starve_no_stall_%0d", i), 32'(stall_req), 32'd0);
            tick();
            chk($sformatf("starve_pipe_%0d", i), 32'(grf_addr), 32'd6);
        end
        chk("starve_stall", 32'(stall_req), 32'd1);
        tick();
        chk_grf("starve_head", 1'b1, 5'd13, 32'hD0, 32'h600);
        chk("starve_cleared", 32'(stall_req), 32'd0);
        tick();
        chk_grf("starve_represent", 1'b1, 5'd6, 32'h60, 32'h500);

        // Reset mid-run with two entries queued
        q_addr1 = 5'd20;
        q_addr2 = 5'd21;
        drive_s(1'b1, 5'd20, 32'hB0, 32'h700);
        tick();
        drive_s(1'b1, 5'd21, 32'hB1, 32'h704);
        tick();
        drive_s(1'b0, 5'd0, 32'h0, 32'h0);
        chk("mid_busy1", 32'(q_busy1), 32'd1);
        chk("mid_busy2", 32'(q_busy2), 32'd1);
        chk("mid_grf_we", 32'(grf_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_grf_we", 32'(grf_we), 32'd0);
        chk("mid_rst_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_busy1", 32'(q_busy1), 32'd0);
        chk("mid_rst_busy2", 32'(q_busy2), 32'd0);
        drive_p(1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(s_ready), 32'd1);
        tick();
        chk("mid_rel_idle", 32'(grf_we), 32'd0);
        chk("mid_rel_busy1", 32'(q_busy1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
